// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver types, oversampling ratio and baud divider helper
//   rx_state_t : receive FSM states
//   OVERSAMPLE : ticks per bit
//   baud_div() : clocks per tick, rounded to nearest
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;
  localparam int OVERSAMPLE = 16;
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + (OVERSAMPLE / 2) * baud) / (OVERSAMPLE * baud);
  endfunction
endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: show-ahead byte stream from the receive FIFO to its consumer
//   data_o  : byte at FIFO head
//   valid_o : FIFO not empty
//   ready_i : consumer accepts data_o
//   level_o : FIFO occupancy
interface uart_rx_fifo_if #(parameter int FIFO_DEPTH = 4);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  logic [7:0] data_o;
  logic valid_o;
  logic ready_i;
  logic [LW-1:0] level_o;
  modport master(output data_o, valid_o, level_o, input ready_i);
  modport slave(input data_o, valid_o, level_o, output ready_i);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: circular-buffer FIFO with registered pointers and show-ahead output
//   clk_i/rst_n_i : clock, synchronous active-low reset
//   push/din      : write request and data (accepted when not full or popping)
//   pop/dout      : read request and head data (dout is 0 while empty)
//   full/empty    : status
//   level         : occupancy
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_pop, do_push;
  // a pop frees a slot first, so a push into a full FIFO succeeds alongside it
  always_comb begin
    empty = level == '0;
    full = level == LW'(DEPTH);
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    dout = empty ? '0 : mem[rd_ptr];
  end
  always_ff @(posedge clk_i)
    if (!rst_n_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level <= '0;
    end else begin
      rd_ptr <= rd_ptr + AW'(do_pop);
      wr_ptr <= wr_ptr + AW'(do_push);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  always_ff @(posedge clk_i)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampled 8N1 UART receiver feeding a byte FIFO
//   clk_i/rst_n_i : core clock, synchronous active-low reset
//   rx_i          : asynchronous serial line (idles high)
//   bus           : show-ahead valid/ready byte stream with FIFO level
//   busy_o        : receiver is mid-frame (FSM not IDLE)
//   frame_err_o   : sticky, stop bit sampled low
//   overrun_o     : sticky, byte completed while FIFO full
//   clear_i       : clears both sticky flags; a coincident error wins
// Build option UART_RX_MAJORITY_EN: 2-of-3 vote over ticks 7..9 of each bit
// window, decided at tick 9, instead of a single sample at tick 8.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 10_000_000,
  parameter int BAUD = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  rx_i,
  input  logic                  clear_i,
  output logic                  busy_o,
  output logic                  frame_err_o,
  output logic                  overrun_o,
  uart_rx_fifo_if.master        bus
);
  localparam int DIV = baud_div(CLK_FREQ_HZ, BAUD);
  localparam int DW = $clog2(DIV + 1);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
`ifdef UART_RX_MAJORITY_EN
  localparam logic [3:0] START_LAST = 4'd8;
`else
  localparam logic [3:0] START_LAST = 4'd7;
`endif
  rx_state_t state, next;
  logic [1:0] sync;
  logic rx_s, tick, decide, bit_s, push, pop, ferr_set, ovr_set, full, empty;
  logic [DW-1:0] div_cnt;
  logic [3:0] tick_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic [LW-1:0] level;
  assign rx_s = sync[1];
  assign tick = div_cnt == DW'(DIV - 1);
  always_ff @(posedge clk_i)
    if (!rst_n_i) begin
      sync <= 2'b11;
      state <= IDLE;
    end else begin
      sync <= {sync[0], rx_i};
      state <= next;
    end
  // divider held at 0 in IDLE so the first tick lands DIV clocks after the start edge
  always_ff @(posedge clk_i)
    if (!rst_n_i) begin
      div_cnt <= '0;
      tick_cnt <= '0;
      bit_idx <= '0;
      shreg <= '0;
      frame_err_o <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      div_cnt <= (state == IDLE || tick) ? '0 : div_cnt + DW'(1);
      tick_cnt <= (state != next) ? '0 : tick_cnt + 4'(tick);
      bit_idx <= (state != DATA) ? '0 : bit_idx + 3'(decide);
      shreg <= (state == DATA && decide) ? {bit_s, shreg[7:1]} : shreg;
      frame_err_o <= ferr_set | (frame_err_o & ~clear_i);
      overrun_o <= ovr_set | (overrun_o & ~clear_i);
    end
`ifdef UART_RX_MAJORITY_EN
  // the two previous tick samples; with the current one they form the vote
  logic [1:0] hist;
  always_ff @(posedge clk_i)
    if (!rst_n_i) hist <= 2'b11;
    else if (tick) hist <= {hist[0], rx_s};
  assign bit_s = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  assign bit_s = rx_s;
`endif
  // START decides mid-bit; afterwards every 16th tick lands mid-bit again
  assign decide = tick && tick_cnt == ((state == START) ? START_LAST : 4'(OVERSAMPLE - 1));
  always_comb begin
    next = state;
    case (state)
      IDLE:      if (!rx_s) next = START;
      START:     if (decide) next = bit_s ? IDLE : DATA;
      DATA:      if (decide && bit_idx == 3'd7) next = STOP;
      STOP:      if (decide) next = bit_s ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rx_s) next = IDLE;
      default:   next = IDLE;
    endcase
  end
  always_comb begin
    pop = !empty && bus.ready_i;
    push = state == STOP && decide && bit_s;
    ferr_set = state == STOP && decide && !bit_s;
    ovr_set = push && full && !pop;
    busy_o = state != IDLE;
    bus.valid_o = !empty;
    bus.level_o = level;
  end
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i(clk_i),
    .rst_n_i(rst_n_i),
    .push(push),
    .pop(pop),
    .din(shreg),
    .dout(bus.data_o),
    .full(full),
    .empty(empty),
    .level(level)
  );
endmodule
